// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle add/sub/logic unit; purely combinational, no flow control.
// Opcodes outside ADD..XOR yield zero result and zero carry.
module alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             c_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    y_o = '0;
    c_o = 1'b0;
    sum = '0;
    case (op_i)
      OP_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y_o = sum[WIDTH-1:0];
        c_o = sum[WIDTH];
      end
      // carry out of a + ~b + 1 doubles as the no-borrow flag
      OP_SUB: begin
        sum = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
        y_o = sum[WIDTH-1:0];
        c_o = sum[WIDTH];
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      default: begin
        y_o = '0;
        c_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: 1-cycle logic/arith, bit-serial shifts (max(1,s) cycles), shift-add MUL (WIDTH cycles).
// start is only accepted in IDLE (including the done cycle); requests while busy are dropped.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  state_t           state_q;
  logic [2:0]       func_q;
  logic [WIDTH-1:0] a_q, b_q, acc_hi_q, acc_lo_q, result_q;
  logic [SW-1:0]    cnt_q;
  logic             carry_q, zero_q, busy_q, done_q;

  logic [WIDTH-1:0] core_y;
  logic             core_c;
  logic [WIDTH-1:0] sh_d;
  logic             sh_out;
  logic [WIDTH:0]   mul_add, mul_sum;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  logic             fin_d;
  logic [WIDTH-1:0] res_d;
  logic             car_d;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (func_q),
    .y_o  (core_y),
    .c_o  (core_c)
  );

  always_comb begin
    sh_d     = (func_q == OP_SLL) ? {acc_lo_q[WIDTH-2:0], 1'b0} : {1'b0, acc_lo_q[WIDTH-1:1]};
    sh_out   = (func_q == OP_SLL) ? acc_lo_q[WIDTH-1] : acc_lo_q[0];
    // {hi,lo} holds partial product over remaining multiplier bits, LSB consumed each cycle
    mul_add  = acc_lo_q[0] ? {1'b0, a_q} : '0;
    mul_sum  = {1'b0, acc_hi_q} + mul_add;
    mul_hi_d = mul_sum[WIDTH:1];
    mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    fin_d = 1'b1;
    res_d = core_y;
    car_d = core_c;
    case (func_q)
      OP_SLL, OP_SRL: begin
        fin_d = (cnt_q <= SW'(1));
        res_d = (cnt_q == '0) ? acc_lo_q : sh_d;
        car_d = (cnt_q != '0) && sh_out;
      end
      OP_MUL: begin
        if (MUL_EN == 0) begin
          fin_d = 1'b1;
          res_d = '0;
          car_d = 1'b0;
        end else begin
          fin_d = (cnt_q == '0);
          res_d = mul_lo_d;
          car_d = |mul_hi_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      func_q   <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            func_q   <= func;
            a_q      <= in1;
            b_q      <= in2;
            acc_hi_q <= '0;
            acc_lo_q <= (func == OP_MUL) ? in2 : in1;
            cnt_q    <= (func == OP_MUL) ? SW'(WIDTH-1) : in2[SW-1:0];
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (fin_d) begin
            result_q <= res_d;
            carry_q  <= car_d;
            zero_q   <= (res_d == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - SW'(1);
            if (func_q == OP_MUL) begin
              acc_hi_q <= mul_hi_d;
              acc_lo_q <= mul_lo_d;
            end else begin
              acc_lo_q <= sh_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: three instances (8-bit with MUL, 8-bit without MUL, 16-bit with MUL).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [2:0]  func = 3'd0;
  logic [15:0] in1 = '0, in2 = '0;

  logic [7:0]  res_a, res_b;
  logic [15:0] res_c;
  logic        car_a, car_b, car_c, zero_a, zero_b, zero_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int          sel = 0;
  logic [15:0] res_s;
  logic        car_s, zero_s, busy_s, done_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8), .MUL_EN(1)) u_w8 (
    .clk(clk), .rst(rst), .start(start_a), .func(func), .in1(in1[7:0]), .in2(in2[7:0]),
    .result(res_a), .carry(car_a), .zero(zero_a), .busy(busy_a), .done(done_a));
  seq_alu #(.WIDTH(8), .MUL_EN(0)) u_w8n (
    .clk(clk), .rst(rst), .start(start_b), .func(func), .in1(in1[7:0]), .in2(in2[7:0]),
    .result(res_b), .carry(car_b), .zero(zero_b), .busy(busy_b), .done(done_b));
  seq_alu #(.WIDTH(16), .MUL_EN(1)) u_w16 (
    .clk(clk), .rst(rst), .start(start_c), .func(func), .in1(in1), .in2(in2),
    .result(res_c), .carry(car_c), .zero(zero_c), .busy(busy_c), .done(done_c));

  always_comb begin
    res_s = '0; car_s = 1'b0; zero_s = 1'b0; busy_s = 1'b0; done_s = 1'b0;
    case (sel)
      0: begin res_s = {8'h00, res_a}; car_s = car_a; zero_s = zero_a; busy_s = busy_a; done_s = done_a; end
      1: begin res_s = {8'h00, res_b}; car_s = car_b; zero_s = zero_b; busy_s = busy_b; done_s = done_b; end
      default: begin res_s = res_c; car_s = car_c; zero_s = zero_c; busy_s = busy_c; done_s = done_c; end
    endcase
  end

  typedef struct {
    int          sel;
    logic [2:0]  f;
    logic [15:0] a, b, er;
    logic        ec, ez;
    int          el;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    start_a = (s == 0) && v;
    start_b = (s == 1) && v;
    start_c = (s == 2) && v;
  endtask

  // Issues one op and returns at the sample point where done is seen (or on timeout).
  task automatic run_op(input int s, input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    sel = s; func = f; in1 = a; in2 = b;
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    in1 = 16'($urandom); in2 = 16'($urandom); func = 3'($urandom);
    lat = 0; bcnt = 0;
    while (!done_s && lat < 40) begin
      if (busy_s) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input int s, input logic [2:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic ec, input logic ez,
                          input int el);
    int lat, bcnt;
    run_op(s, f, a, b, lat, bcnt);
    chk({tag, " latency"}, lat, el);
    chk({tag, " result"}, res_s, er);
    chk({tag, " carry"}, car_s, ec);
    chk({tag, " zero"}, zero_s, ez);
    chk({tag, " busy cycles"}, bcnt, el);
    chk({tag, " busy at done"}, busy_s, 0);
    @(negedge clk);
    chk({tag, " done pulse width"}, done_s, 0);
  endtask

  // Reference behaviour straight from the opcode definitions, using wide integer arithmetic.
  function automatic void model(input int w, input bit mulen, input logic [2:0] f,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned r, output bit c, output int l);
    longint unsigned m = 64'd1 << w;
    int s = int'(b % longint'(w));
    r = 0; c = 0; l = 1;
    case (f)
      3'd0: begin r = (a + b) % m; c = (a + b) >= m; end
      3'd1: begin r = (a + m - b) % m; c = a >= b; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = (a << s) % m; c = (s != 0) && (((a >> (w - s)) & 1) == 1); l = (s == 0) ? 1 : s; end
      3'd6: begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); l = (s == 0) ? 1 : s; end
      default: begin
        if (mulen) begin r = (a * b) % m; c = (a * b) >= m; l = w; end
        else begin r = 0; c = 0; l = 1; end
      end
    endcase
  endfunction

  initial begin
    int lat, bcnt, ndone;

    tbl[0]  = '{0, 3'd0, 16'd24,   16'd16,  16'd40,    1'b0, 1'b0, 1};
    tbl[1]  = '{0, 3'd1, 16'd16,   16'd24,  16'd248,   1'b0, 1'b0, 1};
    tbl[2]  = '{0, 3'd1, 16'd5,    16'd5,   16'd0,     1'b1, 1'b1, 1};
    tbl[3]  = '{0, 3'd5, 16'h81,   16'd3,   16'h08,    1'b0, 1'b0, 3};
    tbl[4]  = '{0, 3'd5, 16'h5A,   16'd8,   16'h5A,    1'b0, 1'b0, 1};
    tbl[5]  = '{0, 3'd6, 16'h81,   16'd1,   16'h40,    1'b1, 1'b0, 1};
    tbl[6]  = '{0, 3'd7, 16'd20,   16'd13,  16'd4,     1'b1, 1'b0, 8};
    tbl[7]  = '{0, 3'd2, 16'hF0,   16'h0F,  16'h00,    1'b0, 1'b1, 1};
    tbl[8]  = '{0, 3'd4, 16'hFF,   16'h0F,  16'hF0,    1'b0, 1'b0, 1};
    tbl[9]  = '{0, 3'd0, 16'd200,  16'd100, 16'd44,    1'b1, 1'b0, 1};
    tbl[10] = '{0, 3'd6, 16'h80,   16'd7,   16'h01,    1'b0, 1'b0, 7};
    tbl[11] = '{1, 3'd7, 16'd20,   16'd13,  16'd0,     1'b0, 1'b1, 1};
    tbl[12] = '{1, 3'd3, 16'h30,   16'h05,  16'h35,    1'b0, 1'b0, 1};
    tbl[13] = '{2, 3'd0, 16'd300,  16'd300, 16'd600,   1'b0, 1'b0, 1};
    tbl[14] = '{2, 3'd7, 16'd300,  16'd300, 16'd24464, 1'b1, 1'b0, 16};
    tbl[15] = '{2, 3'd0, 16'hFFFF, 16'd1,   16'd0,     1'b1, 1'b1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset result i%0d", s), res_s, 0);
      chk($sformatf("reset carry i%0d", s), car_s, 0);
      chk($sformatf("reset zero i%0d", s), zero_s, 1);
      chk($sformatf("reset busy i%0d", s), busy_s, 0);
      chk($sformatf("reset done i%0d", s), done_s, 0);
    end

    for (int i = 0; i < 16; i++)
      check_op($sformatf("vec%0d", i), tbl[i].sel, tbl[i].f, tbl[i].a, tbl[i].b,
               tbl[i].er, tbl[i].ec, tbl[i].ez, tbl[i].el);

    // start while busy must be dropped
    @(negedge clk);
    sel = 0; func = 3'd7; in1 = 16'd20; in2 = 16'd13; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 0;
    while (!done_s && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin start_a = 1'b1; func = 3'd0; in1 = 16'd1; in2 = 16'd1; end
      else start_a = 1'b0;
    end
    start_a = 1'b0;
    chk("busy-ignore latency", lat, 8);
    chk("busy-ignore result", res_s, 4);
    ndone = 0;
    repeat (4) begin @(negedge clk); if (done_s || busy_s) ndone++; end
    chk("busy-ignore no extra op", ndone, 0);
    chk("busy-ignore result held", res_s, 4);

    // back-to-back: start raised in the done cycle
    run_op(0, 3'd0, 16'd1, 16'd2, lat, bcnt);
    chk("b2b first result", res_s, 3);
    func = 3'd0; in1 = 16'd5; in2 = 16'd6; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("b2b accepted busy", busy_s, 1);
    chk("b2b held result", res_s, 3);
    @(negedge clk);
    chk("b2b second done", done_s, 1);
    chk("b2b second result", res_s, 11);

    // reset in the middle of a multiply
    @(negedge clk);
    sel = 0; func = 3'd7; in1 = 16'd20; in2 = 16'd13; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst result", res_s, 0);
    chk("midrst carry", car_s, 0);
    chk("midrst zero", zero_s, 1);
    chk("midrst busy", busy_s, 0);
    chk("midrst done", done_s, 0);
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done_s) ndone++; end
    chk("midrst no done", ndone, 0);
    check_op("post-reset add", 0, 3'd0, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 1);

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      int s, w, el;
      logic [2:0] f;
      longint unsigned a, b, r;
      bit c;
      s = int'($urandom_range(0, 2));
      w = (s == 2) ? 16 : 8;
      f = 3'($urandom);
      a = longint'($urandom) & ((64'd1 << w) - 1);
      b = longint'($urandom) & ((64'd1 << w) - 1);
      model(w, s != 1, f, a, b, r, c, el);
      check_op($sformatf("rnd%0d i%0d op%0d a%0d b%0d", i, s, f, a, b), s, f, 16'(a), 16'(b),
               16'(r), c, r == 0, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
